// File: rtl/chip_cycle_pkg.sv
// Shared definitions for the sound-chip bus cycle generator and the filter
// stage that feeds it: chip target codes, FSM state encoding and the default
// phase timings in clock cycles.
package chip_cycle_pkg;

  typedef enum logic [1:0] {
    CHIP_YM0  = 2'b00,
    CHIP_YM1  = 2'b01,
    CHIP_SAA  = 2'b10,
    CHIP_NONE = 2'b11
  } chip_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int DEF_YM_SETUP  = 1;
  localparam int DEF_YM_PULSE  = 14;
  localparam int DEF_YM_HOLD   = 2;
  localparam int DEF_SAA_SETUP = 3;
  localparam int DEF_SAA_PULSE = 6;
  localparam int DEF_SAA_HOLD  = 1;

  // Either YM accepts reads and writes; the SAA is write-only and code 11
  // addresses nothing, so those requests never start a bus cycle.
  function automatic logic validTarget(input logic wr, input logic [1:0] chip);
    return (chip == CHIP_YM0) || (chip == CHIP_YM1) || ((chip == CHIP_SAA) && wr);
  endfunction

endpackage

// File: rtl/chip_cycle.sv
// Bus cycle generator for two YM chips and one SAA chip. A one-cycle request
// starts a SETUP / PULSE / HOLD sequence timed by one shared down-counter.
// Every output is a flop fed from the next-state logic, so nothing reaches
// the pins combinationally from the inputs.
module chip_cycle
  import chip_cycle_pkg::*;
#(
  parameter int YM_SETUP  = DEF_YM_SETUP,
  parameter int YM_PULSE  = DEF_YM_PULSE,
  parameter int YM_HOLD   = DEF_YM_HOLD,
  parameter int SAA_SETUP = DEF_SAA_SETUP,
  parameter int SAA_PULSE = DEF_SAA_PULSE,
  parameter int SAA_HOLD  = DEF_SAA_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_wr,
  input  logic [1:0] req_chip,
  input  logic       req_a0,
  output logic       busy,
  output logic       overrun,
  output logic       rd_done,
  output logic [1:0] ym_cs_n,
  output logic       ym_rd_n,
  output logic       ym_wr_n,
  output logic       ym_a0,
  output logic       saa_cs_n,
  output logic       saa_wr_n,
  output logic       saa_a0
);

  // The counter is loaded with length-1 and the phase ends when it reads 0.
  localparam logic [3:0] YmSetupLd  = 4'(YM_SETUP - 1);
  localparam logic [3:0] YmPulseLd  = 4'(YM_PULSE - 1);
  localparam logic [3:0] YmHoldLd   = 4'(YM_HOLD - 1);
  localparam logic [3:0] SaaSetupLd = 4'(SAA_SETUP - 1);
  localparam logic [3:0] SaaPulseLd = 4'(SAA_PULSE - 1);
  localparam logic [3:0] SaaHoldLd  = 4'(SAA_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wrLat_q, wrLat_d;
  logic [1:0] chipLat_q, chipLat_d;
  logic       isSaa_d;

  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;
  logic       rdDone_q, rdDone_d;
  logic [1:0] ymCsN_q, ymCsN_d;
  logic       ymRdN_q, ymRdN_d;
  logic       ymWrN_q, ymWrN_d;
  logic       ymA0_q, ymA0_d;
  logic       saaCsN_q, saaCsN_d;
  logic       saaWrN_q, saaWrN_d;
  logic       saaA0_q, saaA0_d;

  // Phase sequencing, request latching and overrun detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wrLat_d   = wrLat_q;
    chipLat_d = chipLat_q;
    ymA0_d    = ymA0_q;
    saaA0_d   = saaA0_q;
    overrun_d = req && (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (req && validTarget(req_wr, req_chip)) begin
          state_d   = ST_SETUP;
          wrLat_d   = req_wr;
          chipLat_d = req_chip;
          if (req_chip == CHIP_SAA) begin
            cnt_d   = SaaSetupLd;
            saaA0_d = req_a0;
          end else begin
            cnt_d  = YmSetupLd;
            ymA0_d = req_a0;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_PULSE;
          cnt_d   = (chipLat_q == CHIP_SAA) ? SaaPulseLd : YmPulseLd;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          cnt_d   = (chipLat_q == CHIP_SAA) ? SaaHoldLd : YmHoldLd;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values for the coming cycle, decoded from the phase being entered.
  always_comb begin
    isSaa_d  = (chipLat_d == CHIP_SAA);
    busy_d   = (state_d != ST_IDLE);
    ymCsN_d  = 2'b11;
    ymRdN_d  = 1'b1;
    ymWrN_d  = 1'b1;
    saaCsN_d = 1'b1;
    saaWrN_d = 1'b1;
    rdDone_d = 1'b0;
    if (isSaa_d) begin
      saaCsN_d = !((state_d == ST_SETUP) || (state_d == ST_PULSE));
      saaWrN_d = !(state_d == ST_PULSE);
    end else if (state_d == ST_PULSE) begin
      ymCsN_d[chipLat_d[0]] = 1'b0;
      ymRdN_d  = wrLat_d;
      ymWrN_d  = !wrLat_d;
      rdDone_d = !wrLat_d && (cnt_d == 4'd0);
    end
  end

  // State, counter, latches and output flops; reset wins over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      wrLat_q   <= 1'b0;
      chipLat_q <= CHIP_NONE;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      rdDone_q  <= 1'b0;
      ymCsN_q   <= 2'b11;
      ymRdN_q   <= 1'b1;
      ymWrN_q   <= 1'b1;
      ymA0_q    <= 1'b0;
      saaCsN_q  <= 1'b1;
      saaWrN_q  <= 1'b1;
      saaA0_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wrLat_q   <= wrLat_d;
      chipLat_q <= chipLat_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      rdDone_q  <= rdDone_d;
      ymCsN_q   <= ymCsN_d;
      ymRdN_q   <= ymRdN_d;
      ymWrN_q   <= ymWrN_d;
      ymA0_q    <= ymA0_d;
      saaCsN_q  <= saaCsN_d;
      saaWrN_q  <= saaWrN_d;
      saaA0_q   <= saaA0_d;
    end
  end

  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign rd_done  = rdDone_q;
  assign ym_cs_n  = ymCsN_q;
  assign ym_rd_n  = ymRdN_q;
  assign ym_wr_n  = ymWrN_q;
  assign ym_a0    = ymA0_q;
  assign saa_cs_n = saaCsN_q;
  assign saa_wr_n = saaWrN_q;
  assign saa_a0   = saaA0_q;

endmodule
